// File: rtl/sfp_vec_add_s_seq.sv
// Vector+scalar signed fixed-point adder that time-shares one adder across N lanes.
// Accepts a vector and a scalar, produces one lane per cycle, and returns the vector with a per-lane overflow mask.
module sfp_vec_add_s_seq #(
  parameter int N     = 3,
  parameter int WIDTH = 32,
  parameter int CLIP  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]     in_s,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WIDTH-1:0]   out_vec,
  output logic [N-1:0]         out_clip_mask,
  output logic                 out_clip,
  output logic                 busy
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]              state;
  logic [IDX_W-1:0]        idx;
  logic [N*WIDTH-1:0]      a_p0;
  logic signed [WIDTH-1:0] s_p0;
  logic [N*WIDTH-1:0]      res_p1;
  logic [N-1:0]            mask_p1;

  logic signed [WIDTH-1:0] a_sel;
  logic signed [WIDTH:0]   sum;
  logic                    lane_ovf;
  logic signed [WIDTH-1:0] lane_res;
  logic                    accept;

  // One extra bit holds the true sign of the sum; the top two bits disagree on overflow.
  function automatic logic signed [WIDTH:0] add_ext(input logic signed [WIDTH-1:0] a,
                                                    input logic signed [WIDTH-1:0] b);
    return {a[WIDTH-1], a} + {b[WIDTH-1], b};
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_clip(input logic signed [WIDTH:0] s);
    logic signed [WIDTH-1:0] r;
    r = s[WIDTH-1:0];
    if (s[WIDTH] != s[WIDTH-1]) begin
      r = s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
    return r;
  endfunction

  assign in_ready      = (state == S_IDLE) && !rst;
  assign accept        = in_valid && in_ready;
  assign out_valid     = (state == S_DONE);
  assign busy          = (state != S_IDLE);
  assign out_vec       = res_p1;
  assign out_clip_mask = mask_p1;
  assign out_clip      = |mask_p1;

  always_comb begin
    a_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == IDX_W'(i)) a_sel = a_p0[i*WIDTH +: WIDTH];
    end
  end

  assign sum      = add_ext(a_sel, s_p0);
  assign lane_ovf = sum[WIDTH] ^ sum[WIDTH-1];
  assign lane_res = (CLIP != 0) ? sat_clip(sum) : sum[WIDTH-1:0];

  // Stage p0: operands captured at accept, untouched until the next accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0 <= in_a;
      s_p0 <= in_s;
    end
  end

  // Stage p1: lane results and overflow mask, filled one lane per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      res_p1  <= '0;
      mask_p1 <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            idx     <= '0;
            res_p1  <= '0;
            mask_p1 <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          for (int i = 0; i < N; i++) begin
            if (idx == IDX_W'(i)) begin
              res_p1[i*WIDTH +: WIDTH] <= lane_res;
              mask_p1[i]               <= lane_ovf;
            end
          end
          if (idx == IDX_W'(N-1)) begin
            state <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sfp_vec_add_s_seq.sv
// Directed bench for sfp_vec_add_s_seq: one saturating and one wrapping instance share the same stimulus.
module tb_sfp_vec_add_s_seq;

  localparam int N = 3;
  localparam int W = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [N*W-1:0]  in_a;
  logic [W-1:0]    in_s;
  logic            out_ready;

  logic            c_in_ready, c_out_valid, c_out_clip, c_busy;
  logic [N*W-1:0]  c_out_vec;
  logic [N-1:0]    c_mask;
  logic            w_in_ready, w_out_valid, w_out_clip, w_busy;
  logic [N*W-1:0]  w_out_vec;
  logic [N-1:0]    w_mask;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sfp_vec_add_s_seq #(.N(N), .WIDTH(W), .CLIP(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_a(in_a), .in_s(in_s), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_vec(c_out_vec), .out_clip_mask(c_mask), .out_clip(c_out_clip), .busy(c_busy)
  );

  sfp_vec_add_s_seq #(.N(N), .WIDTH(W), .CLIP(0)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_a(in_a), .in_s(in_s), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_vec(w_out_vec), .out_clip_mask(w_mask), .out_clip(w_out_clip), .busy(w_busy)
  );

  task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns cycles from the accepting edge until out_valid, bounded.
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!c_out_valid && lat < 20);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [W:0] mdl(input logic [W-1:0] a, input logic [W-1:0] s, input bit clip);
    longint sum;
    logic   ovf;
    logic [W-1:0] r;
    sum = longint'($signed(a)) + longint'($signed(s));
    ovf = (sum > 64'sd2147483647) || (sum < -64'sd2147483648);
    r   = sum[W-1:0];
    if (clip && ovf) r = (sum > 0) ? 32'h7FFFFFFF : 32'h80000000;
    return {ovf, r};
  endfunction

  logic [N*W-1:0] bb_a [4];
  logic [W-1:0]   bb_s [4];
  int             acc_cyc [4];

  initial begin
    int lat;
    logic [N*W-1:0] held;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_s = '0; out_ready = 1'b0;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_in_ready", c_in_ready, 0);
    chk("rst_out_valid", c_out_valid, 0);
    chk("rst_busy", c_busy, 0);
    chk("rst_vec", c_out_vec, 0);
    chk("rst_mask", c_mask, 0);
    chk("rst_clip", c_out_clip, 0);
    rst = 1'b0; #1;
    chk("idle_in_ready", c_in_ready, 1);

    // Basic
    in_a = {32'hFFFF0000, 32'h00020000, 32'h00010000}; in_s = 32'h00008000; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    chk("basic_busy", c_busy, 1);
    chk("basic_in_ready_busy", c_in_ready, 0);
    wait_out(lat);
    chk("basic_latency", lat, 3);
    chk("basic_vec", c_out_vec, {32'hFFFF8000, 32'h00028000, 32'h00018000});
    chk("basic_mask", c_mask, 3'b000);
    chk("basic_clip", c_out_clip, 0);
    handshake();
    chk("basic_hs_valid", c_out_valid, 0);
    chk("basic_hs_in_ready", c_in_ready, 1);

    // Saturation / wrap, positive overflow on lane 0
    in_a = {32'h00000000, 32'h80000000, 32'h7FFF0000}; in_s = 32'h00020000; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    wait_out(lat);
    chk("satp_latency", lat, 3);
    chk("satp_vec", c_out_vec, {32'h00020000, 32'h80020000, 32'h7FFFFFFF});
    chk("satp_mask", c_mask, 3'b001);
    chk("satp_clip", c_out_clip, 1);
    chk("wrap_vec", w_out_vec, {32'h00020000, 32'h80020000, 32'h80010000});
    chk("wrap_mask", w_mask, 3'b001);
    chk("wrap_clip", w_out_clip, 1);
    handshake();

    // Saturation / wrap, negative overflow on lane 1
    in_s = 32'hFFFF0000; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    wait_out(lat);
    chk("satn_vec", c_out_vec, {32'hFFFF0000, 32'h80000000, 32'h7FFE0000});
    chk("satn_mask", c_mask, 3'b010);
    chk("satn_clip", c_out_clip, 1);
    chk("wrapn_vec", w_out_vec, {32'hFFFF0000, 32'h7FFF0000, 32'h7FFE0000});
    chk("wrapn_mask", w_mask, 3'b010);

    // Backpressure with new data pending (result still held from previous vector)
    held = c_out_vec;
    in_a = {32'h00000005, 32'h00000004, 32'h00000003}; in_s = 32'h00000010; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_valid", c_out_valid, 1);
      chk("bp_in_ready", c_in_ready, 0);
      chk("bp_vec_stable", c_out_vec, held);
      chk("bp_mask_stable", c_mask, 3'b010);
    end
    out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("bp_release_in_ready", c_in_ready, 1);
    chk("bp_release_busy", c_busy, 0);
    @(posedge clk); #1; in_valid = 1'b0;
    chk("bp_second_accepted", c_busy, 1);
    wait_out(lat);
    chk("bp_second_latency", lat, 3);
    chk("bp_second_vec", c_out_vec, {32'h00000015, 32'h00000014, 32'h00000013});
    chk("bp_second_mask", c_mask, 3'b000);
    handshake();

    // Reset mid-operation
    in_a = {32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF}; in_s = 32'h00000001; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", c_out_valid, 0);
    chk("midrst_mask", c_mask, 0);
    chk("midrst_busy", c_busy, 0);
    chk("midrst_in_ready", c_in_ready, 0);
    rst = 1'b0; #1;
    chk("postrst_in_ready", c_in_ready, 1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("postrst_no_stale", c_out_valid, 0);
    end

    // Back-to-back with out_ready tied high
    bb_a[0] = {32'h00000003, 32'h00000002, 32'h00000001}; bb_s[0] = 32'h00000010;
    bb_a[1] = {32'h7FFFFFFF, 32'h80000001, 32'h12345678}; bb_s[1] = 32'h00000001;
    bb_a[2] = {32'hFFFFFFFF, 32'h80000000, 32'h40000000}; bb_s[2] = 32'hC0000000;
    bb_a[3] = {32'h00000000, 32'h7FFFFFFE, 32'hDEADBEEF}; bb_s[3] = 32'h00000002;
    out_ready = 1'b1;
    begin
      int k_acc = 0;
      int k_res = 0;
      int cyc   = 0;
      while (k_res < 4 && cyc < 80) begin
        if (c_out_valid) begin
          for (int l = 0; l < N; l++) begin
            logic [W:0] mc, mw;
            mc = mdl(bb_a[k_res][l*W +: W], bb_s[k_res], 1'b1);
            mw = mdl(bb_a[k_res][l*W +: W], bb_s[k_res], 1'b0);
            chk($sformatf("bb%0d_clip_lane%0d", k_res, l), c_out_vec[l*W +: W], mc[W-1:0]);
            chk($sformatf("bb%0d_wrap_lane%0d", k_res, l), w_out_vec[l*W +: W], mw[W-1:0]);
            chk($sformatf("bb%0d_mask%0d", k_res, l), c_mask[l], mc[W]);
          end
          k_res++;
        end
        if (c_in_ready) begin
          if (k_acc < 4) begin
            in_a = bb_a[k_acc]; in_s = bb_s[k_acc]; in_valid = 1'b1;
            acc_cyc[k_acc] = cyc + 1;
            k_acc++;
          end else begin
            in_valid = 1'b0;
          end
        end
        @(posedge clk); #1;
        cyc++;
      end
      chk("bb_all_results", k_res, 4);
      for (int k = 1; k < 4; k++) chk($sformatf("bb_spacing%0d", k), acc_cyc[k] - acc_cyc[k-1], N + 2);
    end
    in_valid = 1'b0; out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
